// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver for 8N1 frames (8E1 when
// UART_RX_PARITY_EN is defined). It samples each bit at its centre
// using the baud_generator oversample tick. Each received byte is
// presented with a one-cycle o_valid strobe plus frame and parity flags.
// A line held low after a bad stop bit is absorbed in BREAK, so a break
// produces exactly one frame-error strobe.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_stick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int TW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] TICK_ZERO = TW'(0);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_ZERO  = BW'(0);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
        ,ST_PARITY = 3'd5
`endif
    } state_e;

`ifdef UART_RX_PARITY_EN
    // Even-parity error: odd number of ones across data plus parity bit.
    function automatic logic even_parity_err(input logic [DATA_BITS-1:0] d,
                                             input logic p);
        return (^d) ^ p;
    endfunction
`endif

    logic                 rx_meta_q;
    logic                 rx_s_q;
    state_e               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 perr_q, perr_d;
    logic                 busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
`endif

    // Two-flop synchronizer for the asynchronous serial line (idle high).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    // FSM, counters, shift register and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            tick_q  <= TICK_ZERO;
            bit_q   <= BIT_ZERO;
            shift_q <= {DATA_BITS{1'b0}};
            data_q  <= {DATA_BITS{1'b0}};
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            perr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Next-state logic: sample at bit centres, assemble the byte, raise status.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = ferr_q;
        perr_d  = perr_q;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // A tick coinciding with the start detection is deliberately not counted.
                if (!rx_s_q) begin
                    state_d = ST_START;
                    tick_d  = TICK_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (i_stick) begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_s_q) begin
                            state_d = ST_DATA;
                            tick_d  = TICK_ZERO;
                            bit_d   = BIT_ZERO;
                        end else begin
                            // Line is high again at mid start bit: glitch.
                            state_d = ST_IDLE;
                            tick_d  = TICK_ZERO;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end

            ST_DATA: begin
                if (i_stick) begin
                    if (tick_q == TICK_LAST) begin
                        // LSB arrives first, so shifting right lands it at bit 0.
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        tick_d  = TICK_ZERO;
                        if (bit_q == BIT_LAST) begin
                            bit_d = BIT_ZERO;
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + BIT_ONE;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (i_stick) begin
                    if (tick_q == TICK_LAST) begin
                        par_d   = even_parity_err(shift_q, rx_s_q);
                        tick_d  = TICK_ZERO;
                        state_d = ST_STOP;
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end
`endif

            ST_STOP: begin
                if (i_stick) begin
                    if (tick_q == TICK_LAST) begin
                        // The byte is delivered even when the stop bit is bad.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        ferr_d  = ~rx_s_q;
`ifdef UART_RX_PARITY_EN
                        perr_d  = par_q;
`else
                        perr_d  = 1'b0;
`endif
                        tick_d  = TICK_ZERO;
                        if (rx_s_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_BREAK;
                        end
                    end else begin
                        tick_d = tick_q + TICK_ONE;
                    end
                end else begin
                    tick_d = tick_q;
                end
            end

            ST_BREAK: begin
                // Absorb a held-low line until it returns to idle.
                if (rx_s_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end

            default: begin
                state_d = ST_IDLE;
                tick_d  = TICK_ZERO;
                bit_d   = BIT_ZERO;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign o_data       = data_q;
    assign o_valid      = valid_q;
    assign o_frame_err  = ferr_q;
    assign o_parity_err = perr_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are built bit by bit at 64 clocks/bit
// with i_stick every 4 clocks. Expected bytes and flags are queued as each
// frame is sent. A negedge monitor checks every o_valid strobe against the
// queue in order.
module tb_uart_rx;

    localparam int BIT_CLKS = 64;

    logic       clk;
    logic       rst_n;
    logic       stick;
    logic       rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_parity_err;
    logic       o_busy;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    exp_t exp_q[$];

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_stick     (stick),
        .i_rx        (rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
        .o_parity_err(o_parity_err),
        .o_busy      (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Oversample tick generator: one pulse every 4 clocks.
    initial begin
        stick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            stick = 1'b1;
            @(negedge clk);
            stick = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: the receiver reports the byte, a low stop bit as a frame
    // error and, with parity built, an odd count of ones (data + parity bit).
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
        exp_t e;
        e.d  = d;
        e.fe = ~stop;
`ifdef UART_RX_PARITY_EN
        e.pe = ((($countones(d) + int'(par)) % 2) == 1);
`else
        e.pe = 1'b0;
`endif
        exp_q.push_back(e);
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clks(BIT_CLKS);
        end
`ifdef UART_RX_PARITY_EN
        rx = par;
        wait_clks(BIT_CLKS);
`endif
        rx = stop;
        wait_clks(BIT_CLKS);
    endtask

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

    // Monitor: every strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got data 0x%0h with no frame pending at %0t", o_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("data", 32'(o_data), 32'(e.d));
                check("frame_err", 32'(o_frame_err), 32'(e.fe));
                check("parity_err", 32'(o_parity_err), 32'(e.pe));
            end
        end
    end

    initial begin
        logic [7:0] rd;
        logic       rstop;
        int         gap;

        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(3);
        check("reset_data", 32'(o_data), 32'd0);
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_ferr", 32'(o_frame_err), 32'd0);
        check("reset_perr", 32'(o_parity_err), 32'd0);
        check("reset_busy", 32'(o_busy), 32'd0);
        rst_n = 1'b1;
        wait_clks(20);

        // Clean frame.
        send_frame(8'hA5, 1'b1, even_par(8'hA5));
        wait_clks(4);
        check("clean_busy_low", 32'(o_busy), 32'd0);
        check("clean_drained", 32'(exp_q.size()), 32'd0);

        // Start glitch: 5 ticks low, then high.
        rx = 1'b0;
        wait_clks(20);
        check("glitch_busy_high", 32'(o_busy), 32'd1);
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        check("glitch_busy_low", 32'(o_busy), 32'd0);
        send_frame(8'h3C, 1'b1, even_par(8'h3C));
        wait_clks(10);

        // Frame error followed by a break of 3 bit times.
        send_frame(8'h5A, 1'b0, even_par(8'h5A));
        wait_clks(3 * BIT_CLKS);
        check("break_busy", 32'(o_busy), 32'd1);
        check("break_single_strobe", 32'(exp_q.size()), 32'd0);
        rx = 1'b1;
        wait_clks(8);
        check("break_released", 32'(o_busy), 32'd0);
        send_frame(8'hC3, 1'b1, even_par(8'hC3));

        // Back-to-back frames with no idle gap.
        send_frame(8'h00, 1'b1, even_par(8'h00));
        send_frame(8'hFF, 1'b1, even_par(8'hFF));
        send_frame(8'h81, 1'b1, even_par(8'h81));
        wait_clks(10);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Reset during data bit 3 of 0x77.
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 3; i++) begin
            rx = 1'(8'h77 >> i);
            wait_clks(BIT_CLKS);
        end
        rx = 1'b0;
        wait_clks(30);
        check("pre_reset_busy", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        rx    = 1'b1;
        wait_clks(2);
        check("midreset_data", 32'(o_data), 32'd0);
        check("midreset_valid", 32'(o_valid), 32'd0);
        check("midreset_ferr", 32'(o_frame_err), 32'd0);
        check("midreset_busy", 32'(o_busy), 32'd0);
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("post_reset_idle", 32'(o_busy), 32'd0);
        send_frame(8'h12, 1'b1, even_par(8'h12));
        wait_clks(10);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h03, 1'b1, 1'b1);
        send_frame(8'h07, 1'b1, 1'b1);
        wait_clks(10);
`endif

        // Randomized frames, some with a low stop bit, random gaps.
        for (int n = 0; n < 16; n++) begin
            rd    = 8'($urandom_range(0, 255));
            rstop = ($urandom_range(0, 3) != 0);
            send_frame(rd, rstop, 1'($urandom_range(0, 1)));
            rx  = 1'b1;
            gap = $urandom_range(0, 30);
            if (!rstop) begin
                gap = gap + 10;
            end
            wait_clks(gap);
        end

        wait_clks(100);
        check("final_drained", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(o_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
